// File: rtl/nco_quad_rom.sv
// Quadrature NCO: phase accumulator, quarter-wave table, quadrant folding.
// Define NCO_DITHER_EN to add LFSR dither ahead of phase truncation.
module nco_quad_rom #(
   parameter int    PHASE_W   = 32,
   parameter int    ADDR_W    = 10,
   parameter int    DATA_W    = 16,
   parameter string INIT_FILE = "sin_quarter1024.hex"
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     clr,
   input  logic [PHASE_W-1:0]       ftw,
   input  logic [PHASE_W-1:0]       poff,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] cos_o,
   output logic signed [DATA_W-1:0] sin_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int PW    = ADDR_W + 2;
   localparam real PI   = 3.14159265358979323846;

   // Table holds the INIT_FILE image, built at elaboration from its formula
   function automatic logic [DATA_W-1:0] qval(input int k);
      real a;
      real s;
      a = 2.0 * PI * (real'(k) + 0.5) / (2.0 ** (ADDR_W + 2));
      s = ((2.0 ** (DATA_W - 1)) - 1.0) * $sin(a);
      return DATA_W'($rtoi(s + 0.5));
   endfunction

   logic [DATA_W-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic [DATA_W-1:0] QV = qval(k);
      assign rom[k] = QV;
   end

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] acc_eff;
   logic [PHASE_W-1:0] dith;
   logic [PHASE_W-1:0] ph;
   logic [PW-1:0]      p;
   logic [ADDR_W-1:0]  idx;
   logic [ADDR_W-1:0]  as_n;
   logic [ADDR_W-1:0]  ac_n;

`ifdef NCO_DITHER_EN
   localparam int FW = PHASE_W - PW;
   localparam int D  = (FW < 16) ? FW : 16;

   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= 16'hACE1;
      else if (en)
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign dith = PHASE_W'(lfsr >> (16 - D));
`else
   assign dith = '0;
`endif

   always_comb begin
      acc_eff = clr ? '0 : acc;
      ph      = acc_eff + poff + dith;
      p       = ph[PHASE_W-1 -: PW];
      idx     = p[ADDR_W-1:0];
      as_n    = p[ADDR_W] ? ~idx : idx;
      ac_n    = p[ADDR_W] ? idx : ~idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else
         acc <= en ? acc_eff + ftw : acc_eff;
   end

   logic [ADDR_W-1:0] a_sin;
   logic [ADDR_W-1:0] a_cos;
   logic [1:0]        q1;
   logic [1:0]        q2;
   logic              v1;
   logic              v2;
   logic [DATA_W-1:0] d_sin;
   logic [DATA_W-1:0] d_cos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sin <= '0;
         a_cos <= '0;
         q1    <= '0;
         v1    <= 1'b0;
      end else begin
         a_sin <= as_n;
         a_cos <= ac_n;
         q1    <= p[PW-1:ADDR_W];
         v1    <= en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_sin <= '0;
         d_cos <= '0;
         q2    <= '0;
         v2    <= 1'b0;
      end else begin
         d_sin <= rom[a_sin];
         d_cos <= rom[a_cos];
         q2    <= q1;
         v2    <= v1;
      end
   end

   // sin is negative in quadrants 2,3; cos in quadrants 1,2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sin_o     <= '0;
         cos_o     <= '0;
      end else begin
         out_valid <= v2;
         if (v2) begin
            sin_o <= q2[1] ? -d_sin : d_sin;
            cos_o <= (q2[1] ^ q2[0]) ? -d_cos : d_cos;
         end
      end
   end

endmodule
